// File: rtl/riscv_pkg.sv
// Purpose : Shared definitions for the RV32 instruction-fetch front end.
// Contents: NOP encoding, default reset PC, fetch FSM state enum and a
//           word-alignment helper used when taking a redirect target.
package riscv_pkg;

    // addi x0, x0, 0 -- canonical RV32I no-op fed to decode on bubbles.
    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // FETCH : issuing a request at pc
    // WAIT  : one request accepted, response pending
    // HOLD  : response parked in the skid buffer while decode stalls
    // DRAIN : response of a squashed request still to come; drop it
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    // Instruction addresses are word aligned; low two bits of a jump
    // target are dropped rather than trapped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Purpose : One-entry skid buffer that parks an instruction response
//           (word + its fetch address) when decode stalls on arrival.
// Ports   : clk, rst     - clock, synchronous active-high reset
//           load         - capture in_inst/in_pc, mark entry valid
//           clear        - drop the entry (wins over load)
//           in_inst/in_pc- response word and its fetch address
//           valid        - entry holds a parked instruction
//           inst/pc      - parked word and address
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc
);

    // NOTE: sequential state is always written with non-blocking (<=)
    // assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // NOTE: the payload is deliberately not reset; it is only consumed
    // while valid=1, and leaving it unreset keeps it a plain enable flop.
    always_ff @(posedge clk) begin
        if (load) begin
            inst <= in_inst;
            pc   <= in_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Purpose : RV32 instruction fetch stage. Issues one word fetch at a time
//           to instruction memory, fills the IF/ID pipeline register, and
//           handles decode stalls (via a skid buffer) and execute redirects.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           imem_req/imem_addr  - fetch request and word-aligned address
//           imem_gnt            - request accepted this cycle
//           imem_rvalid/rdata   - instruction response
//           stall               - decode cannot accept; hold IF/ID
//           redirect/redirect_pc- taken control transfer from execute
//           id_valid/id_inst/id_pc/id_pc_plus4 - IF/ID register
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    fetch_state_e state;
    logic [31:0]  pc;        // next address to request
    logic [31:0]  req_pc;    // address of the outstanding request

    logic         issue;     // request accepted this cycle
    logic         take_resp; // response goes straight into IF/ID
    logic         release_skid;
    logic         skid_load;
    logic         skid_clear;
    logic         skid_valid;
    logic [31:0]  skid_inst;
    logic [31:0]  skid_pc;

    // Request is combinational so that, with a 1-cycle memory, a new
    // request goes out in the same cycle the previous response lands.
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        imem_req = 1'b0;
        if (!rst && !redirect) begin
            unique case (state)
                FETCH:   imem_req = 1'b1;
                WAIT:    imem_req = imem_rvalid && !stall;
                default: imem_req = 1'b0;
            endcase
        end
    end

    assign imem_addr    = pc;
    assign issue        = imem_req && imem_gnt;
    assign take_resp    = !redirect && (state == WAIT) && imem_rvalid && !stall;
    assign release_skid = !redirect && (state == HOLD) && !stall;
    assign skid_load    = !rst && !redirect && (state == WAIT) && imem_rvalid && stall;
    assign skid_clear   = redirect || release_skid;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clear   (skid_clear),
        .in_inst (imem_rdata),
        .in_pc   (req_pc),
        .valid   (skid_valid),
        .inst    (skid_inst),
        .pc      (skid_pc)
    );

    // Only meaningful while a request is outstanding, so no reset.
    always_ff @(posedge clk) begin
        if (issue) begin
            req_pc <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_inst     <= NOP;
            id_pc       <= RESET_PC;
            id_pc_plus4 <= RESET_PC + 32'd4;
        end else begin
            // Program counter: redirect beats the sequential increment.
            if (redirect) begin
                pc <= align_word(redirect_pc);
            end else if (issue) begin
                pc <= pc + 32'd4;
            end

            // IF/ID register.
            if (redirect) begin
                id_valid <= 1'b0;
                id_inst  <= NOP;
            end else if (take_resp) begin
                id_valid    <= 1'b1;
                id_inst     <= imem_rdata;
                id_pc       <= req_pc;
                id_pc_plus4 <= req_pc + 32'd4;
            end else if (release_skid && skid_valid) begin
                id_valid    <= 1'b1;
                id_inst     <= skid_inst;
                id_pc       <= skid_pc;
                id_pc_plus4 <= skid_pc + 32'd4;
            end else if (!stall) begin
                id_valid <= 1'b0;
                id_inst  <= NOP;
            end

            // Sequencing. A stray rvalid in FETCH or HOLD is ignored.
            unique case (state)
                FETCH: begin
                    if (issue) state <= WAIT;
                end
                WAIT: begin
                    if (redirect) begin
                        // A response arriving with the redirect is simply
                        // dropped; otherwise it must still be drained.
                        state <= imem_rvalid ? FETCH : DRAIN;
                    end else if (imem_rvalid) begin
                        if (stall)      state <= HOLD;
                        else if (issue) state <= WAIT;
                        else            state <= FETCH;
                    end
                end
                HOLD: begin
                    if (redirect || !stall) state <= FETCH;
                end
                DRAIN: begin
                    // The squashed response is the last one owed to us;
                    // once it lands there is nothing left to drain even
                    // if another redirect arrives in the same cycle.
                    if (imem_rvalid) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port imem_req  output  1  fetch request valid.
REQ-005 SHALL have port imem_addr  output  32  fetch byte address, word-aligned.
REQ-006 SHALL have port imem_gnt  input  1  request accepted this cycle when imem_req=1.
REQ-007 SHALL have port imem_rvalid  input  1  response valid, at least 1 cycle after acceptance.
REQ-008 SHALL have port imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-009 SHALL have port stall  input  1  decode cannot accept; hold IF/ID contents.
REQ-010 SHALL have port redirect  input  1  taken branch/jal/jalr from execute.
REQ-011 SHALL have port redirect_pc  input  32  redirect target, valid with redirect.
REQ-012 SHALL have port id_valid  output  1  IF/ID register holds a real instruction.
REQ-013 SHALL have port id_inst  output  32  instruction to decoder; NOP when id_valid=0.
REQ-014 SHALL have port id_pc  output  32  address of id_inst.
REQ-015 SHALL have port id_pc_plus4  output  32  id_pc+4 for jal/jalr link writeback.

Function
REQ-016 SHALL implement states FETCH, WAIT, HOLD, DRAIN; at most one outstanding request.
REQ-017 FETCH: imem_req=1, imem_addr=pc; on imem_gnt, pc<=pc+4 (mod 2^32, wraps at 32'hFFFF_FFFC to 0) and go to WAIT.
REQ-018 WAIT, imem_rvalid=1, stall=0, redirect=0: load IF/ID (id_valid=1, id_inst=imem_rdata, id_pc=fetch address); imem_req asserted same cycle at pc (back-to-back, 1 instr/cycle with 1-cycle memory); on gnt stay WAIT, else go FETCH.
REQ-019 WAIT, imem_rvalid=1, stall=1: response captured into one-entry skid buffer with its pc; go HOLD; no request issued.
REQ-020 HOLD: imem_req=0; when stall=0, skid moves to IF/ID next edge, skid cleared, go FETCH.
REQ-021 stall=1 with no redirect: id_valid, id_inst, id_pc, id_pc_plus4 unchanged.
REQ-022 stall=0 and no instruction loaded this edge: id_valid<=0, id_inst<=NOP (32'h0000_0013).
REQ-023 redirect SHALL take priority over stall and rvalid: pc<=redirect_pc with bits [1:0] forced 0; id_valid<=0, id_inst<=NOP; skid cleared; imem_req=0 that cycle.
REQ-024 Redirect while a request is outstanding without rvalid that cycle: go DRAIN; redirect coinciding with rvalid: response discarded, go FETCH.
REQ-025 DRAIN: imem_req=0; next imem_rvalid discarded, then go FETCH; further redirect in DRAIN updates pc, stays DRAIN.
REQ-026 id_pc_plus4 SHALL equal id_pc+4 mod 2^32 whenever id_valid=1.
REQ-027 Latency: request granted at cycle N, rvalid at N+1 -> id_valid=1 after edge N+2.
REQ-028 imem_rvalid in FETCH or HOLD SHALL be ignored (protocol violation, no state change).

Reset
REQ-029 While rst=1 at an edge: pc<=RESET_PC, state<=FETCH, id_valid<=0, id_inst<=NOP, id_pc<=RESET_PC, id_pc_plus4<=RESET_PC+4, skid empty; imem_req=0 during reset cycles.
REQ-030 Reset mid-request SHALL abandon the outstanding request; rvalid arriving after reset before any new grant SHALL be ignored.

Structure
REQ-031 Shared package riscv_pkg SHALL hold NOP constant, fetch state enum, default RESET_PC.
REQ-032 Skid buffer SHALL be sub-module fetch_skid_buf (one entry: inst, pc, valid, load/clear).

Verification
REQ-033 Reset, RESET_PC=0, imem always gnt, rvalid 1 cycle later -> id_pc 0,4,8,12 on consecutive cycles, id_valid=1 each.
REQ-034 stall held 3 cycles while rvalid arrives for pc=8 -> id_inst/pc frozen, word for 8 appears the cycle after stall drops, no request issued during HOLD.
REQ-035 redirect to 32'h0000_0103 while request outstanding -> following rvalid discarded, next imem_addr=32'h0000_0100, id_valid=0 meanwhile.
REQ-036 redirect and stall asserted together -> id_valid<=0, id_inst=32'h0000_0013, fetch from target next cycle.
REQ-037 RESET_PC=32'hFFFF_FFFC, continuous fetch -> second imem_addr=0, id_pc_plus4 of first instruction=0.
REQ-038 rst asserted in WAIT, stale rvalid next cycle -> ignored; first id_pc after reset = RESET_PC.
